// File: rtl/fma_issue_ctrl_if.sv
// Bundles the operand-in, MAC-issue and result-out handshakes of the FMA issue controller.
// The slave modport is the controller's view; the master modport is its environment's view.
interface fma_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic [XLEN-1:0] c_i;
    logic            a_inf_i, a_zero_i, a_nan_i;
    logic            b_inf_i, b_zero_i, b_nan_i;
    logic            c_inf_i, c_zero_i, c_nan_i;

    logic            mac_valid_o;
    logic [XLEN-1:0] mac_a_o;
    logic [XLEN-1:0] mac_b_o;
    logic [XLEN-1:0] mac_c_o;
    logic [XLEN-1:0] mac_result_i;

    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] out_data_o;
    logic            out_nv_o;

    modport slave (
        input  in_valid_i, a_i, b_i, c_i,
        input  a_inf_i, a_zero_i, a_nan_i, b_inf_i, b_zero_i, b_nan_i, c_inf_i, c_zero_i, c_nan_i,
        output in_ready_o,
        output mac_valid_o, mac_a_o, mac_b_o, mac_c_o,
        input  mac_result_i,
        output out_valid_o, out_data_o, out_nv_o,
        input  out_ready_i
    );

    modport master (
        output in_valid_i, a_i, b_i, c_i,
        output a_inf_i, a_zero_i, a_nan_i, b_inf_i, b_zero_i, b_nan_i, c_inf_i, c_zero_i, c_nan_i,
        input  in_ready_o,
        input  mac_valid_o, mac_a_o, mac_b_o, mac_c_o,
        output mac_result_i,
        input  out_valid_o, out_data_o, out_nv_o,
        output out_ready_i
    );
endinterface

// File: rtl/fma_issue_ctrl.sv
// FMA issue controller: resolves IEEE special cases locally, issues normal ops to a fixed-latency
// MAC pipe, and returns all results in order through a credit-protected output FIFO.
module fma_issue_ctrl #(
    parameter int PARM_XLEN  = 32,
    parameter int PARM_EXP   = 8,
    parameter int PARM_MANT  = 23,
    parameter int PARM_LAT   = 3,
    parameter int PARM_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    fma_issue_ctrl_if.slave bus
);
    localparam int CW = $clog2(PARM_DEPTH + 1);
    localparam int AW = (PARM_DEPTH > 1) ? $clog2(PARM_DEPTH) : 1;
    localparam logic [PARM_XLEN-1:0] QNAN =
        {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};

    typedef struct packed {
        logic                 valid;
        logic                 special;
        logic                 nv;
        logic [PARM_XLEN-1:0] data;
    } trk_t;

    // ---------------- classification of the incoming operand set ----------------
    logic                 sa, sb, sc;
    logic                 prod_inf, any_nan, any_snan;
    logic                 cls_special, cls_nv;
    logic [PARM_XLEN-1:0] cls_data;
    logic                 unused_c_zero;

    assign unused_c_zero = bus.c_zero_i;

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        sa          = bus.a_i[PARM_XLEN-1];
        sb          = bus.b_i[PARM_XLEN-1];
        sc          = bus.c_i[PARM_XLEN-1];
        prod_inf    = bus.a_inf_i | bus.b_inf_i;
        any_nan     = bus.a_nan_i | bus.b_nan_i | bus.c_nan_i;
        any_snan    = (bus.a_nan_i & ~bus.a_i[PARM_MANT-1]) |
                      (bus.b_nan_i & ~bus.b_i[PARM_MANT-1]) |
                      (bus.c_nan_i & ~bus.c_i[PARM_MANT-1]);
        cls_special = 1'b1;
        cls_nv      = 1'b0;
        cls_data    = QNAN;
        if (any_nan) begin
            cls_nv = any_snan;
        end else if ((bus.a_inf_i & bus.b_zero_i) | (bus.a_zero_i & bus.b_inf_i)) begin
            cls_nv = 1'b1;
        end else if (prod_inf & bus.c_inf_i & ((sa ^ sb) != sc)) begin
            cls_nv = 1'b1;
        end else if (prod_inf) begin
            cls_data = {sa ^ sb, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
        end else if (bus.c_inf_i) begin
            cls_data = bus.c_i;
        end else begin
            cls_special = 1'b0;
            cls_data    = '0;
        end
    end

    // ---------------- credit counter: accepted but not yet popped ----------------
    logic          accept, pop, out_valid;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;

    assign accept = bus.in_valid_i & in_ready_q;
    assign pop    = out_valid & bus.out_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if (accept & ~pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (~accept & pop) begin
            cnt_d = cnt_q - CW'(1);
        end
        in_ready_d = (cnt_d < CW'(PARM_DEPTH));
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready_o = in_ready_q;

    // ---------------- MAC issue registers ----------------
    logic                 mac_valid_q;
    logic [PARM_XLEN-1:0] mac_a_q, mac_b_q, mac_c_q;
    logic                 issue;

    assign issue = accept & ~cls_special;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mac_valid_q <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_c_q     <= '0;
        end else begin
            mac_valid_q <= issue;
            if (issue) begin
                mac_a_q <= bus.a_i;
                mac_b_q <= bus.b_i;
                mac_c_q <= bus.c_i;
            end
        end
    end

    assign bus.mac_valid_o = mac_valid_q;
    assign bus.mac_a_o     = mac_a_q;
    assign bus.mac_b_o     = mac_b_q;
    assign bus.mac_c_o     = mac_c_q;

    // ---------------- tracking pipe: stage k holds an op k cycles after its issue slot ----------------
    trk_t trk_q [PARM_LAT+1];
    trk_t trk_in;

    assign trk_in = {accept, cls_special, cls_nv, cls_data};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i <= PARM_LAT; i++) begin
                trk_q[i] <= '0;
            end
        end else begin
            trk_q[0] <= trk_in;
            for (int i = 1; i <= PARM_LAT; i++) begin
                trk_q[i] <= trk_q[i-1];
            end
        end
    end

    // ---------------- output FIFO; the wrap bit separates full from empty ----------------
    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    logic               push;
    logic [PARM_XLEN:0] push_entry;
    logic [PARM_XLEN:0] head;
    logic [PARM_XLEN:0] mem_q [PARM_DEPTH];

    assign push       = trk_q[PARM_LAT].valid;
    assign push_entry = {trk_q[PARM_LAT].nv,
                         trk_q[PARM_LAT].special ? trk_q[PARM_LAT].data : bus.mac_result_i};

    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(PARM_DEPTH - 1)) begin
            return {~p[AW], {AW{1'b0}}};
        end
        return p + (AW+1)'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    // NOTE: storage is not reset; the pointers define which entries are live, and the outputs are masked while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
        end
    end

    assign out_valid       = (wr_ptr_q != rd_ptr_q);
    assign head            = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_valid ? head[PARM_XLEN-1:0] : '0;
    assign bus.out_nv_o    = out_valid & head[PARM_XLEN];
endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Scoreboard bench for fma_issue_ctrl: a reference classifier and MAC model predict every result,
// which is queued at accept and compared when the controller hands the result out.
module tb_fma_issue_ctrl;
    localparam int XLEN  = 32;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic a_inf, a_zero, a_nan;
        logic b_inf, b_zero, b_nan;
        logic c_inf, c_zero, c_nan;
    } flags_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fma_issue_ctrl_if #(.XLEN(XLEN)) bus ();

    fma_issue_ctrl #(
        .PARM_XLEN (XLEN),
        .PARM_EXP  (8),
        .PARM_MANT (23),
        .PARM_LAT  (LAT),
        .PARM_DEPTH(DEPTH)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int mac_pulses = 0;
    int outs_seen = 0;
    logic [32:0] sb_q [$];
    logic [95:0] mac_q [$];
    logic [31:0] dp_pipe [LAT+1];
    logic        hold_armed = 1'b0;
    logic [32:0] hold_val;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] det1(input logic [31:0] x);
        logic ones, zexp, zman;
        ones = (x[30:23] == 8'hFF);
        zexp = (x[30:23] == 8'h00);
        zman = (x[22:0] == 23'd0);
        return {ones & zman, zexp & zman, ones & ~zman};
    endfunction

    function automatic logic [31:0] mac_model(input logic [31:0] a, b, c);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && c == 32'h3F80_0000) return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + c;
    endfunction

    // Returns {special, nv, data}.
    function automatic logic [33:0] ref_out(input logic [31:0] a, b, c, input flags_t f);
        logic sa, sb, sc, snan;
        sa   = a[31];
        sb   = b[31];
        sc   = c[31];
        snan = (f.a_nan && !a[22]) || (f.b_nan && !b[22]) || (f.c_nan && !c[22]);
        if (f.a_nan || f.b_nan || f.c_nan)                  return {1'b1, snan, QNAN};
        if ((f.a_inf && f.b_zero) || (f.a_zero && f.b_inf)) return {1'b1, 1'b1, QNAN};
        if (f.a_inf || f.b_inf) begin
            if (f.c_inf && ((sa ^ sb) != sc))                return {1'b1, 1'b1, QNAN};
            return {1'b1, 1'b0, sa ^ sb, 8'hFF, 23'd0};
        end
        if (f.c_inf)                                         return {1'b1, 1'b0, c};
        return {1'b0, 1'b0, mac_model(a, b, c)};
    endfunction

    // Fixed-latency datapath model; keeps running through reset.
    assign bus.mac_result_i = dp_pipe[LAT];
    initial begin
        for (int i = 0; i <= LAT; i++) dp_pipe[i] = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            for (int i = LAT; i > 0; i--) dp_pipe[i] = dp_pipe[i-1];
            dp_pipe[0] = bus.mac_valid_o ? mac_model(bus.mac_a_o, bus.mac_b_o, bus.mac_c_o)
                                         : 32'hDEAD_BEEF;
        end
    end

    // Output / issue monitor, sampled mid-cycle.
    initial begin
        logic [32:0] exp_o;
        logic [95:0] exp_m;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_armed = 1'b0;
            end else begin
                if (bus.mac_valid_o) begin
                    mac_pulses++;
                    if (mac_q.size() == 0) begin
                        check("mac_unexpected", 1, 0);
                    end else begin
                        exp_m = mac_q.pop_front();
                        check("mac_operands", {bus.mac_a_o, bus.mac_b_o, bus.mac_c_o}, exp_m);
                    end
                end
                if (hold_armed)
                    check("out_hold", {bus.out_valid_o, bus.out_nv_o, bus.out_data_o}, {1'b1, hold_val});
                if (bus.out_valid_o && bus.out_ready_i) begin
                    outs_seen++;
                    if (sb_q.size() == 0) begin
                        check("out_unexpected", {bus.out_nv_o, bus.out_data_o}, 0);
                    end else begin
                        exp_o = sb_q.pop_front();
                        check("out_result", {bus.out_nv_o, bus.out_data_o}, exp_o);
                    end
                end
                hold_armed = bus.out_valid_o && !bus.out_ready_i;
                hold_val   = {bus.out_nv_o, bus.out_data_o};
            end
        end
    end

    task automatic send(input logic [31:0] a, b, c);
        flags_t      f;
        logic [33:0] r;
        logic        rdy;
        int          waited;
        f = {det1(a), det1(b), det1(c)};
        bus.a_i = a;
        bus.b_i = b;
        bus.c_i = c;
        {bus.a_inf_i, bus.a_zero_i, bus.a_nan_i,
         bus.b_inf_i, bus.b_zero_i, bus.b_nan_i,
         bus.c_inf_i, bus.c_zero_i, bus.c_nan_i} = f;
        bus.in_valid_i = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            rdy = bus.in_ready_o;
            @(posedge clk);
            if (rdy) break;
            waited++;
            if (waited > 100) break;
        end
        if (rdy) begin
            r = ref_out(a, b, c, f);
            sb_q.push_back(r[32:0]);
            if (!r[33]) mac_q.push_back({a, b, c});
        end else begin
            check("send_timeout", waited, 0);
        end
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic meas_lat(input string tag);
        int n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.out_valid_o) break;
        end
        check(tag, n, LAT + 1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb_q.size() != 0 || bus.out_valid_o) && n < 300) begin
            @(posedge clk);
            n++;
        end
        check(tag, sb_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [31:0] st_a [8] = '{32'h3F800000, 32'h7F800000, 32'h40400000, 32'h3F800000,
                              32'h7FC00000, 32'h40A00000, 32'hC0000000, 32'h7F800000};
    logic [31:0] st_b [8] = '{32'h40000000, 32'h00000000, 32'h40000000, 32'h40000000,
                              32'h3F800000, 32'h3F000000, 32'h40000000, 32'hBF800000};
    logic [31:0] st_c [8] = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'hFF800000,
                              32'h3F800000, 32'h41200000, 32'h00000000, 32'h3F800000};

    initial begin
        int p0, o0;
        bus.in_valid_i  = 1'b0;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.c_i         = '0;
        {bus.a_inf_i, bus.a_zero_i, bus.a_nan_i,
         bus.b_inf_i, bus.b_zero_i, bus.b_nan_i,
         bus.c_inf_i, bus.c_zero_i, bus.c_nan_i} = '0;
        bus.out_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid_o, 0);
        check("rst_mac_valid", bus.mac_valid_o, 0);
        check("rst_out_data", {bus.out_nv_o, bus.out_data_o}, 0);
        check("rst_mac_ops", {bus.mac_a_o, bus.mac_b_o, bus.mac_c_o}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready_o, 1);

        // Normal op: one-cycle issue pulse, LAT+1 accept-to-output latency
        send(32'h3F800000, 32'h40000000, 32'h3F800000);
        check("t1_mac_pulse", bus.mac_valid_o, 1);
        meas_lat("t1_latency");
        drain("t1_drain");

        // Inf*0 resolves locally with the same latency and never issues
        p0 = mac_pulses;
        send(32'h7F800000, 32'h00000000, 32'h3F800000);
        check("t2_no_pulse", bus.mac_valid_o, 0);
        meas_lat("t2_latency");
        drain("t2_drain");
        check("t2_no_mac", mac_pulses - p0, 0);

        // Special-case priority table
        send(32'hFF800000, 32'h3F800000, 32'h7F800000);
        send(32'hFF800000, 32'h3F800000, 32'hFF800000);
        send(32'h7F800001, 32'h3F800000, 32'h3F800000);
        send(32'h7FC00001, 32'h3F800000, 32'h3F800000);
        send(32'h00000000, 32'hFF800000, 32'h40000000);
        send(32'h40000000, 32'h3F800000, 32'hFF800000);
        send(32'h7F800000, 32'h40000000, 32'h7F800000);
        send(32'h7F800000, 32'h00000000, 32'h7FC00000);
        drain("t3_drain");

        // Credit throttle with a blocked consumer, then ordered drain under random backpressure
        o0 = outs_seen;
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send(st_a[i], st_b[i], st_c[i]);
            check("t5_in_ready", bus.in_ready_o, (i < DEPTH - 1));
        end
        repeat (6) @(posedge clk);
        #1;
        check("t5_stalled_ready", bus.in_ready_o, 0);
        check("t5_stalled_valid", bus.out_valid_o, 1);
        fork
            begin
                for (int i = DEPTH; i < 8; i++) send(st_a[i], st_b[i], st_c[i]);
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready_i = 1'($urandom_range(0, 1));
                end
                bus.out_ready_i = 1'b1;
            end
        join
        drain("t5_drain");
        check("t5_count", outs_seen - o0, 8);

        // Reset with three ops in flight
        send(32'h40400000, 32'h40000000, 32'h3F800000);
        send(32'h40A00000, 32'h3F000000, 32'h41200000);
        send(32'hC0000000, 32'h40000000, 32'h3F800000);
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", bus.out_valid_o, 0);
        check("t6_mac_valid", bus.mac_valid_o, 0);
        check("t6_out_data", {bus.out_nv_o, bus.out_data_o}, 0);
        check("t6_mac_ops", {bus.mac_a_o, bus.mac_b_o, bus.mac_c_o}, 0);
        sb_q.delete();
        mac_q.delete();
        o0 = outs_seen;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("t6_no_out", outs_seen - o0, 0);
        check("t6_ready", bus.in_ready_o, 1);
        send(32'h3F800000, 32'h40000000, 32'h3F800000);
        meas_lat("t6_latency");
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end
endmodule
